// File: rtl/param_cache_pkg.sv
// param_cache_pkg: shared state encoding and helper functions for the cache
package param_cache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return (v >= m) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/cache_tag_store.sv
// cache_tag_store: direct-mapped valid/tag/data arrays with combinational lookup
module cache_tag_store
  import param_cache_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int LINES   = 4
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic [A_WIDTH-1:0] addr_i,
  output logic               hit_o,
  output logic [D_WIDTH-1:0] rdata_o,
  input  logic               fill_i,
  input  logic               upd_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic               flush_i
);
  localparam int IDX = clog2(LINES);
  localparam int TW  = A_WIDTH - IDX;
  logic [LINES-1:0]   valid_q;
  logic [TW-1:0]      tag_q  [LINES];
  logic [D_WIDTH-1:0] data_q [LINES];
  logic [IDX-1:0]     idx;
  logic [TW-1:0]      tag;
  assign idx     = addr_i[IDX-1:0];
  assign tag     = addr_i[A_WIDTH-1:IDX];
  assign hit_o   = valid_q[idx] && (tag_q[idx] == tag);
  assign rdata_o = data_q[idx];
  // valid bits: flush clears all, a completing fill re-validates its own line
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) valid_q <= '0;
    else begin
      if (flush_i) valid_q <= '0;
      if (fill_i) valid_q[idx] <= 1'b1;
    end
  end
  // tag/data arrays: fill writes tag and data, a write hit only refreshes data
  always_ff @(posedge g_clk) begin
    if (fill_i) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= wdata_i;
    end else if (upd_i) data_q[idx] <= wdata_i;
  end
endmodule

// File: rtl/param_cache.sv
// param_cache: direct-mapped write-through cache with flush and saturating stats
module param_cache
  import param_cache_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 8,
  parameter int LINES     = 4,
  parameter int MEM_LAT   = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 g_clk,
  input  logic                 g_clr,
  input  logic [A_WIDTH-1:0]   cpu_addr,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [D_WIDTH-1:0]   cpu_wdata,
  output logic [D_WIDTH-1:0]   cpu_rdata,
  output logic                 odv,
  input  logic                 flush,
  output logic [A_WIDTH-1:0]   mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [D_WIDTH-1:0]   mem_wdata,
  input  logic [D_WIDTH-1:0]   mem_rdata,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);
  localparam int WW = clog2(MEM_LAT + 1);
  state_e               state_q;
  logic [A_WIDTH-1:0]   addr_q;
  logic [D_WIDTH-1:0]   wdata_q;
  logic                 mem_rd_q, mem_wr_q, done_q;
  logic [WW-1:0]        wait_q;
  logic [CNT_WIDTH-1:0] hit_q, miss_q;
  logic [A_WIDTH-1:0]   look_addr;
  logic                 hit, last, rd_req, wr_req;
  logic [D_WIDTH-1:0]   hit_rdata;
  assign look_addr = (state_q == IDLE) ? cpu_addr : addr_q;
  assign last      = (state_q != IDLE) && (wait_q == WW'(MEM_LAT - 1));
  assign wr_req    = (state_q == IDLE) && !done_q && cpu_wr;
  assign rd_req    = (state_q == IDLE) && !done_q && cpu_rd && !cpu_wr;
  assign odv       = g_clr && ((state_q == IDLE) ? !(wr_req || (rd_req && !hit)) : last);
  assign cpu_rdata = !odv ? '0 : (state_q == FILL) ? mem_rdata : rd_req ? hit_rdata : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  cache_tag_store #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .LINES(LINES)) u_store (
    .g_clk  (g_clk),
    .g_clr  (g_clr),
    .addr_i (look_addr),
    .hit_o  (hit),
    .rdata_o(hit_rdata),
    .fill_i (state_q == FILL && last),
    .upd_i  (state_q == WRITE && last && hit),
    .wdata_i((state_q == FILL) ? mem_rdata : wdata_q),
    .flush_i(flush)
  );
  // controller: accepts requests in IDLE, runs RAM accesses, counts hits/misses
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      wait_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            state_q  <= WRITE;
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            mem_wr_q <= 1'b1;
            wait_q   <= '0;
          end else if (rd_req && !hit) begin
            state_q  <= FILL;
            addr_q   <= cpu_addr;
            mem_rd_q <= 1'b1;
            wait_q   <= '0;
            miss_q   <= CNT_WIDTH'(sat_inc(32'(miss_q), CNT_WIDTH));
          end else if (rd_req) hit_q <= CNT_WIDTH'(sat_inc(32'(hit_q), CNT_WIDTH));
        end
        FILL, WRITE: begin
          if (last) begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
          end else wait_q <= wait_q + WW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: scoreboard bench for param_cache with a latency-modelled RAM
module tb_param_cache;
  localparam int ML = 2;
  typedef struct {
    logic [7:0] data;
    int         lat;
  } sb_t;
  logic       g_clk = 1'b0, g_clr = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic       cpu_rd = 1'b0, cpu_wr = 1'b0, odv, flush = 1'b0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd, mem_wr;
  logic [3:0] hit_cnt, miss_cnt;
  int         n_chk = 0, n_err = 0;
  sb_t        sb[$];
  logic [7:0] refm [256];
  bit         wmask [256];
  logic [7:0] wram [256];
  always #5 g_clk = ~g_clk;
  param_cache #(.D_WIDTH(8), .A_WIDTH(8), .LINES(4), .MEM_LAT(ML), .CNT_WIDTH(4)) dut (
    .g_clk(g_clk), .g_clr(g_clr), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .odv(odv), .flush(flush),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  function automatic logic [7:0] dflt(input logic [7:0] a);
    return (a == 8'h05) ? 8'hA7 : (a == 8'h09) ? 8'h51 : a ^ 8'h5A;
  endfunction
  assign mem_rdata = wmask[mem_addr] ? wram[mem_addr] : dflt(mem_addr);
  always @(posedge g_clk) if (mem_wr) begin
    wmask[mem_addr] <= 1'b1;
    wram[mem_addr]  <= mem_wdata;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic xact(input logic w, input logic [7:0] a, input logic [7:0] d, input logic exp_hit, input logic fl);
    sb_t e;
    int  cyc, strobes;
    bit  done;
    e.lat  = (w || !exp_hit) ? ML : 0;
    e.data = w ? d : refm[a];
    sb.push_back(e);
    if (w) refm[a] = d;
    cpu_addr = a; cpu_wdata = d; cpu_rd = !w; cpu_wr = w;
    cyc = 0; strobes = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge g_clk);
      if (w ? (mem_wr && mem_addr == a && mem_wdata == d) : (mem_rd && mem_addr == a)) strobes++;
      if (fl && mem_rd) flush = 1'b1;
      if (odv) done = 1; else cyc++;
    end
    if (!done) chk("timeout", 0, 1);
    e = sb.pop_front();
    chk(w ? "wr_lat" : "rd_lat", cyc, e.lat);
    chk(w ? "wr_strobes" : "rd_strobes", strobes, e.lat);
    if (!w) chk("rd_data", cpu_rdata, e.data);
    @(posedge g_clk); #1;
    cpu_rd = 0; cpu_wr = 0; flush = 0;
    @(posedge g_clk); #1;
    if (w) chk("ram_updated", mem_rdata_at(a), d);
  endtask
  function automatic logic [7:0] mem_rdata_at(input logic [7:0] a);
    return wmask[a] ? wram[a] : dflt(a);
  endfunction
  initial begin
    for (int i = 0; i < 256; i++) refm[i] = dflt(8'(i));
    #12;
    chk("rst_odv", odv, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    @(negedge g_clk); g_clr = 1;
    @(posedge g_clk); #1;
    chk("idle_odv", odv, 1);
    xact(0, 8'h05, 0, 0, 0);
    chk("miss1", miss_cnt, 1);
    xact(0, 8'h05, 0, 1, 0);
    chk("hit1", hit_cnt, 1);
    xact(0, 8'h09, 0, 0, 0);
    xact(0, 8'h05, 0, 0, 0);
    chk("conflict_miss", miss_cnt, 3);
    xact(1, 8'h05, 8'h3C, 0, 0);
    xact(0, 8'h05, 0, 1, 0);
    xact(1, 8'h06, 8'h77, 0, 0);
    xact(0, 8'h06, 0, 0, 0);
    chk("no_alloc_miss", miss_cnt, 4);
    flush = 1; @(posedge g_clk); #1; flush = 0;
    xact(0, 8'h05, 0, 0, 0);
    xact(0, 8'h09, 0, 0, 1);
    xact(0, 8'h09, 0, 1, 0);
    chk("flush_fill_valid", hit_cnt, 3);
    cpu_addr = 8'h05; cpu_rd = 1;
    @(posedge g_clk); #1;
    chk("fill_started", mem_rd, 1);
    g_clr = 0; #1;
    chk("clr_mem_rd", mem_rd, 0);
    chk("clr_odv", odv, 0);
    chk("clr_miss", miss_cnt, 0);
    cpu_rd = 0;
    @(negedge g_clk); g_clr = 1;
    @(posedge g_clk); #1;
    xact(0, 8'h05, 0, 0, 0);
    chk("post_clr_miss", miss_cnt, 1);
    for (int i = 0; i < 20; i++) xact(0, 8'h05, 0, 1, 0);
    chk("hit_sat", hit_cnt, 15);
    chk("miss_after_sat", miss_cnt, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/param_cache.md
Name: param_cache

Overview:
- Parametrised direct-mapped cache that sits between a pipeline stage and a single-port RAM.
- Serves both the instruction path (D_WIDTH=16) and the data path (D_WIDTH=8).
- Replaces the fixed 4-line cache with configurable geometry, a configurable memory latency and a flush input.
- Adds saturating hit and miss counters, and keeps the odv (output data valid) handshake to the controller.

Parameters:
- D_WIDTH, 8: data word width in bits.
- A_WIDTH, 8: address width in bits.
- LINES, 4: number of cache lines, one word per line. Must be a power of 2, at least 2.
- MEM_LAT, 1: RAM access time in cycles. Must be at least 1.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- g_clk  in  1  clock.
- g_clr  in  1  reset, asynchronous, active-low.
- cpu_addr  in  A_WIDTH  request address.
- cpu_rd  in  1  read request; held until odv=1.
- cpu_wr  in  1  write request; held until odv=1.
- cpu_wdata  in  D_WIDTH  write data.
- cpu_rdata  out  D_WIDTH  read data; valid only when odv=1.
- odv  out  1  request complete / data valid.
- flush  in  1  invalidate all lines.
- mem_addr  out  A_WIDTH  RAM address.
- mem_rd  out  1  RAM read strobe.
- mem_wr  out  1  RAM write strobe.
- mem_wdata  out  D_WIDTH  RAM write data.
- mem_rdata  in  D_WIDTH  RAM read data; valid on the final cycle of mem_rd.
- hit_cnt  out  CNT_WIDTH  read-hit count.
- miss_cnt  out  CNT_WIDTH  read-miss count.

Behaviour:
- Address split: IDX = clog2(LINES) bits; index = cpu_addr[IDX-1:0]; tag = cpu_addr[A_WIDTH-1:IDX].
- Hit = valid[index] AND stored tag == tag.
- Reset (g_clr=0), asynchronous:
  - state <- IDLE; all valid bits, wait counter and both statistics counters <- 0.
  - mem_rd, mem_wr, odv <- 0; mem_addr, mem_wdata, cpu_rdata <- 0.
  - Tag and data arrays are not cleared.
  - Reset mid-FILL or mid-WRITE abandons the access; the strobes drop immediately.
- State IDLE:
  - No request: odv=1.
  - cpu_wr=1: go to WRITE, odv=0. Write has priority when cpu_rd and cpu_wr are both 1.
  - cpu_rd=1 and hit: odv=1 in the same cycle; cpu_rdata = line data (combinational); hit_cnt+1. Stay in IDLE.
  - cpu_rd=1 and miss: odv=0; miss_cnt+1; latch address; go to FILL.
- State FILL:
  - mem_rd=1 and mem_addr = latched address, registered, for MEM_LAT cycles (cycles 1..MEM_LAT after the request).
  - Final cycle: odv=1; cpu_rdata = mem_rdata; on the next edge write data, tag and valid=1 into the line, then go to IDLE.
  - Read-miss latency is MEM_LAT+1 cycles.
  - The held request seen in the following IDLE cycle is not counted again; a one-cycle "just completed" flag suppresses it.
- State WRITE (write-through, no write-allocate):
  - mem_wr=1 with latched address and data for MEM_LAT cycles.
  - Final cycle: odv=1; if the line hits, update its data, otherwise leave the line untouched. Then go to IDLE.
  - The completed flag suppresses re-issue of the held write.
- flush=1 at any edge clears all valid bits.
  - A fill in progress still completes and sets its own line valid.
  - Flush in the same edge as a FILL completion: the completing line ends valid.
- Counters saturate at all ones and do not wrap.
- A request is sampled only in IDLE. Changes to cpu_addr or cpu_wdata during FILL or WRITE are ignored.

Decomposition:
- Package param_cache_pkg:
  - state enum: IDLE=2'd0, FILL=2'd1, WRITE=2'd2.
  - clog2 function.
  - saturating-increment function.
- Sub-module cache_tag_store:
  - Holds the LINES-entry valid, tag and data arrays.
  - Combinational lookup (hit, rdata).
  - Synchronous single-line write and whole-array flush.
  - Asynchronous clear of the valid bits.
- param_cache holds the FSM, the wait counter, the latches and the statistics counters.

Test Plan:
Common setup: D_WIDTH=8, A_WIDTH=8, LINES=4, MEM_LAT=2, CNT_WIDTH=4; RAM model has mem[0x05]=0xA7 and mem[0x09]=0x51.
- Read miss then hit:
  - Read 0x05 after reset -> odv=0 in cycle 0; mem_rd=1 in cycles 1-2 with mem_addr=0x05; odv=1 and cpu_rdata=0xA7 in cycle 2; miss_cnt=1.
  - Read 0x05 again -> odv=1 in the same cycle, data 0xA7; hit_cnt=1.
- Conflict: read 0x05, read 0x09 (index 1, different tag), read 0x05 -> three misses; miss_cnt=3; data 0xA7, 0x51, 0xA7.
- Write-through:
  - Fill 0x05, then write 0x3C to 0x05 -> mem_wr=1 for 2 cycles with mem_wdata=0x3C; odv=1 on the second; next read 0x05 hits with 0x3C.
  - Write 0x77 to 0x06 -> RAM updated; next read 0x06 misses (no allocate).
- Flush: fill 0x05, pulse flush for 1 cycle, read 0x05 -> miss with mem_rd asserted; flush coinciding with a FILL completion leaves that line valid.
- Reset mid-FILL: drive g_clr low in FILL cycle 1 -> mem_rd=0 and odv=0 immediately; after release, read 0x05 misses and miss_cnt=1.
- Saturation: one miss then 20 read hits -> hit_cnt=15 with no wrap.
